// File: rtl/seq_adder_pkg.sv
// Shared types and default sizing for the sequential slice adder.
package seq_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SLICE = 4;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build the ripple slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/slice_ripple_adder.sv
// SLICE-bit ripple-carry chain of full_adder cells; also exposes the carry
// into the slice MSB so the top level can derive signed overflow.
module slice_ripple_adder
    import seq_adder_pkg::*;
#(
    parameter int SLICE = DEF_SLICE
) (
    input  logic [SLICE-1:0] A,
    input  logic [SLICE-1:0] B,
    input  logic             Cin,
    output logic [SLICE-1:0] S,
    output logic             Cout,
    output logic             Cin_msb
);

    logic [SLICE:0] c;

    assign c[0] = Cin;

    for (genvar i = 0; i < SLICE; i++) begin : g_bit
        full_adder u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .ci (c[i]),
            .s  (S[i]),
            .co (c[i+1])
        );
    end

    assign Cout    = c[SLICE];
    assign Cin_msb = c[SLICE-1];

endmodule

// File: rtl/seq_slice_adder.sv
// Multi-cycle adder/subtractor: one SLICE-bit ripple slice per clock, LSB first.
// Define SEQ_ADDER_OVF_EN to build the signed-overflow flag V (otherwise V=0).
module seq_slice_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Sub,
    input  logic             Cin,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V,
    output logic             Busy,
    output logic             Done
);

    localparam int N     = WIDTH / SLICE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic [SLICE-1:0] slice_a, slice_b, slice_sum;
    logic             slice_cout;
`ifdef SEQ_ADDER_OVF_EN
    logic             slice_cmsb;
    logic             v_q, v_d;
`else
    logic             unused_slice_cmsb;
`endif

    assign slice_a = a_q[int'(idx_q)*SLICE +: SLICE];
    assign slice_b = b_q[int'(idx_q)*SLICE +: SLICE];

    slice_ripple_adder #(
        .SLICE (SLICE)
    ) u_slice (
        .A       (slice_a),
        .B       (slice_b),
        .Cin     (carry_q),
        .S       (slice_sum),
        .Cout    (slice_cout),
`ifdef SEQ_ADDER_OVF_EN
        .Cin_msb (slice_cmsb)
`else
        .Cin_msb (unused_slice_cmsb)
`endif
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SEQ_ADDER_OVF_EN
        v_d     = v_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    // Subtraction is A + ~B + 1: invert B and force the carry-in.
                    a_d     = A;
                    b_d     = Sub ? ~B : B;
                    carry_d = Sub ? 1'b1 : Cin;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                s_d[int'(idx_q)*SLICE +: SLICE] = slice_sum;
                carry_d = slice_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    cout_d  = slice_cout;
`ifdef SEQ_ADDER_OVF_EN
                    v_d     = slice_cmsb ^ slice_cout;
`endif
                    idx_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SEQ_ADDER_OVF_EN
            v_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef SEQ_ADDER_OVF_EN
            v_q     <= v_d;
`endif
        end
    end

    // Operand registers are only meaningful after a Start, so they carry no reset.
    always_ff @(posedge Clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign S    = s_q;
    assign Cout = cout_q;
`ifdef SEQ_ADDER_OVF_EN
    assign V    = v_q;
`else
    assign V    = 1'b0;
`endif
    assign Busy = (state_q != ST_IDLE);
    assign Done = (state_q == ST_DONE);

endmodule
